// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int          MD_XLEN   = 32;
  localparam int          MD_ITER   = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_signed1(input muldiv_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed2(input muldiv_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_seq_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (output start, funct3, in1, in2, flush,
                  input  busy, valid, result);
  modport slave  (input  start, funct3, in1, in2, flush,
                  output busy, valid, result);
endinterface

// File: rtl/md_addsub33.sv
// Combinational 33-bit adder/subtractor shared by multiply accumulate and divide trial.
module md_addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);
  logic [33:0] full;

  // On subtract, cout=1 means no borrow, i.e. a >= b.
  assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'b0, sub};
  assign sum  = full[32:0];
  assign cout = full[33];
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: 32-step shift-add multiply / restoring divide with
// early-out for divide-by-zero and signed overflow.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int ITER = MD_ITER
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(ITER) + 1;

  md_state_e       state, state_nx;
  muldiv_op_e      op_q, op_in;
  logic            s1_q, s2_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, valid_q;
  logic [XLEN-1:0] result_q;

  logic            neg1, neg2, div_in, div0, ovf, early, accept;
  logic [XLEN-1:0] mag1, mag2, early_res;

  assign op_in  = muldiv_op_e'(bus.funct3);
  assign neg1   = op_signed1(op_in) & bus.in1[XLEN-1];
  assign neg2   = op_signed2(op_in) & bus.in2[XLEN-1];
  assign mag1   = neg1 ? -bus.in1 : bus.in1;
  assign mag2   = neg2 ? -bus.in2 : bus.in2;
  assign div_in = op_is_div(op_in);
  assign div0   = div_in && (bus.in2 == '0);
  assign ovf    = (op_in inside {MD_DIV, MD_REM}) && (bus.in1 == INT_MIN) && (bus.in2 == '1);
  assign early  = div0 || ovf;
  assign accept = (state inside {ST_IDLE, ST_DONE}) && bus.start && !bus.flush;

  always_comb begin
    early_res = '0;
    if (div0)                 early_res = (op_in inside {MD_DIV, MD_DIVU}) ? DIV0_QUOT : bus.in1;
    else if (op_in == MD_DIV) early_res = INT_MIN;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) state_nx = early ? ST_DONE : ST_CALC;
          else           state_nx = ST_IDLE;
        end
        ST_CALC: if (cnt_q == CW'(ITER - 1)) state_nx = ST_FIX;
        ST_FIX:  state_nx = ST_DONE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Multiply keeps {hi, lo} = {acc, multiplier}; divide keeps {hi, lo} = {remainder, dividend/quotient}.
  logic            is_div_q, cout;
  logic [XLEN:0]   add_a, add_b, sum;

  assign is_div_q = op_is_div(op_q);
  assign add_a    = is_div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
  assign add_b    = (is_div_q || lo_q[0]) ? {1'b0, opb_q} : '0;

  md_addsub33 u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (is_div_q),
    .sum (sum),
    .cout(cout)
  );

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  assign prod_fix = (s1_q ^ s2_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix = (s1_q ^ s2_q) ? -lo_q : lo_q;
  assign rem_fix  = s1_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MD_MUL;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      busy_q  <= state_nx inside {ST_CALC, ST_FIX};
      valid_q <= (state_nx == ST_DONE);
      if (accept) begin
        op_q  <= op_in;
        s1_q  <= neg1;
        s2_q  <= neg2;
        hi_q  <= '0;
        cnt_q <= '0;
        lo_q  <= div_in ? mag1 : mag2;
        opb_q <= div_in ? mag2 : mag1;
        if (early) result_q <= early_res;
      end else if (state == ST_CALC && !bus.flush) begin
        cnt_q <= cnt_q + CW'(1);
        if (is_div_q) begin
          hi_q <= cout ? sum[XLEN-1:0] : add_a[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], cout};
        end else begin
          hi_q <= sum[XLEN:1];
          lo_q <= {sum[0], lo_q[XLEN-1:1]};
        end
      end else if (state == ST_FIX && !bus.flush) begin
        result_q <= fix_res;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases, flush, reset and random ops.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the RV32M arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic signed [31:0] sa, sb, sq;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin ps = 64'(sa) * 64'(sb); return ps[63:32]; end
      3'd2: begin ps = 64'(sa) * $signed({32'b0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sq = sa % sb; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.in1    = a;
    bus.in2    = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Observes cycles 1..40 after the start edge; checks latency, busy span, result, single pulse.
  task automatic watch(input string tag, input int lat, input logic [31:0] res_exp);
    int vcyc = -1;
    int nvalid = 0;
    int nbusy = 0;
    logic [31:0] res = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.valid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = k;
          res  = bus.result;
        end
      end
      if (vcyc >= 0 && k > vcyc) break;
    end
    check({tag, " latency"}, vcyc, lat);
    check({tag, " result"}, res, res_exp);
    check({tag, " busy_cycles"}, nbusy, (lat == 1) ? 0 : 33);
    check({tag, " valid_pulses"}, nvalid, 1);
  endtask

  logic [2:0]  d_f [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                            32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_r [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                            32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  int          d_l [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          vcyc;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.in1    = '0;
    bus.in2    = '0;
    #2;
    check("reset busy", bus.busy, 0);
    check("reset valid", bus.valid, 0);
    check("reset result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      launch(d_f[i], d_a[i], d_b[i]);
      watch($sformatf("directed%0d", i), d_l[i], d_r[i]);
    end

    // Flush mid-divide: result must keep the previous value (14).
    launch(3'd5, 32'd100, 32'd7);
    watch("pre_flush", 34, 32'd14);
    launch(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush busy", bus.busy, 0);
    check("flush valid", bus.valid, 0);
    check("flush result", bus.result, 32'd14);
    launch(3'd0, 32'd3, 32'd4);
    watch("post_flush_mul", 34, 32'd12);

    // Back-to-back: start held in the DONE cycle.
    launch(3'd0, 32'd7, 32'hFFFF_FFFD);
    vcyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.valid) begin
        vcyc = k;
        break;
      end
    end
    check("b2b first latency", vcyc, 34);
    check("b2b first result", bus.result, 32'hFFFF_FFEB);
    bus.start  = 1'b1;
    bus.funct3 = 3'd5;
    bus.in1    = 32'd100;
    bus.in2    = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    watch("b2b second", 34, 32'd14);

    // Asynchronous reset during CALC.
    launch(3'd5, 32'hFFFF_FFFF, 32'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("pre_reset busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreset busy", bus.busy, 0);
    check("midreset valid", bus.valid, 0);
    check("midreset result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(3'd5, 32'd9, 32'd3);
    watch("after_reset divu", 34, 32'd3);

    // Random operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(7, 0));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7, 0))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(15, 1));
        3: a = 32'($urandom_range(255, 0));
        default: ;
      endcase
      launch(f, a, b);
      watch($sformatf("rand%0d f=%0d a=%h b=%h", i, f, a, b), exp_latency(f, a, b), model(f, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle RV32M multiply/divide sequencer in the EX stage, alongside the single-cycle ALU. On a start pulse it captures operands and funct3, then iterates a shared 33-bit add/subtract datapath for 32 cycles: shift-add for multiply, restoring divide for divide. It drives busy so the hazard unit stalls IF/ID/EX, and pulses valid with the 32-bit result. RISC-V corner cases (divide by zero, signed overflow) resolve early without iterating.

Parameters:
XLEN, 32, operand/result width; only 32 is supported, fixed for the RV32 core.
ITER, 32, iteration count; must equal XLEN.

Ports:
clk  input  1  core clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
in1  input  32  rs1 operand (dividend / multiplicand).
in2  input  32  rs2 operand (divisor / multiplier).
flush  input  1  synchronous abort from branch/trap redirect.
busy  output  1  registered; high in CALC and FIX.
valid  output  1  registered; one-cycle pulse in DONE.
result  output  32  registered; holds last completed result until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: state=IDLE, busy=0, valid=0, result=0, all internal registers 0. Reset mid-operation discards the operation and produces no valid.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start: capture funct3, sign flags, and operand magnitudes.
  - Signed operands: MULH (both), MULHSU (in1 only), DIV and REM (both). MUL is sign-agnostic; MULHU, DIVU and REMU are unsigned.
  - Divide-by-zero (in2=0, any divide op) -> DONE; quotient=0xFFFFFFFF, remainder=in1.
  - Signed overflow (DIV/REM, in1=0x80000000, in2=0xFFFFFFFF) -> DONE; quotient=0x80000000, remainder=0.
  - Otherwise -> CALC with iteration counter=0.
- CALC: one iteration per cycle; counter increments; after 32 iterations -> FIX.
  - Multiply: 64-bit {acc, mplier} shift-add using the 33-bit adder.
  - Divide: restoring; trial subtract remainder-divisor, set the quotient bit if non-negative.
- FIX: conditional two's-complement negation.
  - 64-bit product is negated when the operand signs differ.
  - Quotient is negated when s1^s2.
  - Remainder takes the sign of s1.
  - Select output: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register result and go to DONE.
- DONE: valid=1 for exactly one cycle. Then to IDLE, or restart if start=1; back-to-back issue has no bubble.
- Latency, with start sampled at edge 0:
  - Normal ops: busy=1 for cycles 1..33, valid=1 in cycle 34.
  - Early-out ops: valid=1 in cycle 1, busy stays 0.
- start asserted in CALC/FIX is ignored (the pipeline is stalled, so it is illegal).
- flush has highest priority over start and iteration: next state IDLE, busy=0 next cycle, no valid, result unchanged. flush in DONE suppresses nothing already visible (valid is already registered) but blocks a simultaneous start.
- All arithmetic is modulo 2^32 or 2^64. The 33-bit adder carry-out is the divide trial sign bit.

Decomposition:
- Package muldiv_pkg:
  - funct3 enum muldiv_op_e (MD_MUL..MD_REMU).
  - state enum md_state_e.
  - Constants MD_ITER=32, DIV0_QUOT=32'hFFFF_FFFF, INT_MIN=32'h8000_0000.
- Sub-module md_addsub33: combinational 33-bit add/subtract (sub input, carry-out), instantiated once and shared by the multiply accumulate and the divide trial subtract.
- FSM, counter, operand registers and sign fix-up remain in muldiv_seq.

Test Plan:
- MUL in1=7, in2=0xFFFFFFFD -> result 0xFFFFFFEB; busy high cycles 1..33; valid single pulse at cycle 34.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each valid at cycle 1 with busy=0; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIV start, flush at cycle 10 -> busy=0 at cycle 11, no valid, result keeps prior value; a new MUL 3*4 issued at cycle 12 -> valid with 12 at cycle 46; start held in the DONE cycle launches the next op with no bubble.
- rst_n low mid-CALC (cycle 20) -> busy/valid/result go to 0 immediately; after release, start DIVU 9/3 -> valid with 3 after 34 cycles.
